dot_product_stream: RTL and testbench

Parametrised, streaming successor to the single-shot 10-lane dot-product unit. Accepts pixel/weight vectors as a sequence of LANES-wide beats over a valid/ready handshake, accumulates across beats, and emits one saturated fixed-point result per vector with output backpressure. Sits between the pixel/weight fetch logic and the classifier/activation stage.

---
 rtl/dot_product_stream.sv | 174 +++++++++++++++++
 tb/tb_dot_product_stream.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_stream.sv
// Streaming dot-product unit: LANES-wide pixel x weight beats accumulated per vector, result saturated to Q10.16.
// Optional DOTPROD_RELU_EN: clamp negative results to zero after saturation.

module dot_product_lane #(
  parameter int PIX_W = 10,
  parameter int WGT_W = 19,
  parameter int PW    = PIX_W + WGT_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_W-1:0]     pix,
  input  logic [WGT_W-1:0]     wgt,
  output logic signed [PW-1:0] prod_q
);
  logic signed [PW-1:0] a, b, prod_d;

  // Pixel is unsigned, so it gets a zero sign bit before the signed multiply.
  always_comb begin
    a      = PW'($signed({1'b0, pix}));
    b      = PW'($signed(wgt));
    prod_d = a * b;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) prod_q <= '0;
    else     prod_q <= prod_d;
endmodule

module dot_product_stream #(
  parameter int LANES     = 10,
  parameter int PIX_W     = 10,
  parameter int WGT_W     = 19,
  parameter int MAX_BEATS = 64,
  parameter int OUT_W     = 26
) (
  input  logic                   clk,
  input  logic                   GlobalReset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [LANES*PIX_W-1:0] Pixels,
  input  logic [LANES*WGT_W-1:0] Weights,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       value,
  output logic                   overflow
);
  localparam int PW = PIX_W + WGT_W + 1;
  localparam int SW = PW + $clog2(LANES);
  localparam int AW = SW + $clog2(MAX_BEATS);
  localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic signed [AW-1:0] MAX_A = AW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] MIN_A = ~MAX_A;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              vld_pipe_q, vld_pipe_d;
  logic [2:0]              first_pipe_q, first_pipe_d;
  logic [2:0]              last_pipe_q, last_pipe_d;
  logic [LANES-1:0][PW-1:0] prod_q;
  logic signed [SW-1:0]    sum_q, sum_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [OUT_W-1:0]        value_q, value_d, sat_val;
  logic                    ovf_q, ovf_d, sat_ovf;
  logic                    accept, is_last;

  // S1: per-lane product registers
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dot_product_lane #(.PIX_W(PIX_W), .WGT_W(WGT_W), .PW(PW)) u_lane (
      .clk    (clk),
      .rst    (GlobalReset),
      .pix    (Pixels[g*PIX_W +: PIX_W]),
      .wgt    (Weights[g*WGT_W +: WGT_W]),
      .prod_q (prod_q[g])
    );
  end

  always_comb begin
    in_ready  = ((state_q == IDLE) || (state_q == ACCUM)) && !GlobalReset;
    accept    = in_valid && in_ready;
    is_last   = in_last || (cnt_q == CW'(MAX_BEATS - 1));
    out_valid = (state_q == OUT);
    value     = value_q;
    overflow  = ovf_q;
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) sum_d = sum_d + SW'($signed(prod_q[i]));
  end

  always_comb begin
    vld_pipe_d   = {vld_pipe_q[1:0], accept};
    first_pipe_d = {first_pipe_q[1:0], accept && (state_q == IDLE)};
    last_pipe_d  = {last_pipe_q[1:0], accept && is_last};
    acc_d        = acc_q;
    // A vector's first beat restarts the sum instead of adding to the old one.
    if (vld_pipe_q[1]) acc_d = (first_pipe_q[1] ? '0 : acc_q) + AW'(sum_q);
  end

  always_comb begin
    sat_ovf = 1'b0;
    sat_val = acc_q[OUT_W-1:0];
    if (acc_q > MAX_A) begin
      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
      sat_ovf = 1'b1;
    end else if (acc_q < MIN_A) begin
      sat_val = {1'b1, {(OUT_W-1){1'b0}}};
      sat_ovf = 1'b1;
    end
`ifdef DOTPROD_RELU_EN
    if (sat_val[OUT_W-1]) begin
      sat_val = '0;
      sat_ovf = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (is_last) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            state_d = ACCUM;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        // Last beat has just landed in the accumulator.
        if (vld_pipe_q[2] && last_pipe_q[2]) begin
          state_d = OUT;
          value_d = sat_val;
          ovf_d   = sat_ovf;
        end
      end
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
      last_pipe_q  <= '0;
      sum_q        <= '0;
      acc_q        <= '0;
      value_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vld_pipe_q   <= vld_pipe_d;
      first_pipe_q <= first_pipe_d;
      last_pipe_q  <= last_pipe_d;
      sum_q        <= sum_d;
      acc_q        <= acc_d;
      value_q      <= value_d;
      ovf_q        <= ovf_d;
    end
  end
endmodule

// File: tb/tb_dot_product_stream.sv
// Bench for dot_product_stream: arithmetic reference model plus directed vectors with literal results.
module tb_dot_product_stream;
  localparam int LANES = 10, PIX_W = 10, WGT_W = 19, MAX_BEATS = 64, OUT_W = 26;

  logic                   clk, GlobalReset, in_valid, in_ready, in_last;
  logic [LANES*PIX_W-1:0] Pixels;
  logic [LANES*WGT_W-1:0] Weights;
  logic                   out_valid, out_ready, overflow;
  logic [OUT_W-1:0]       value;

  dot_product_stream #(.LANES(LANES), .PIX_W(PIX_W), .WGT_W(WGT_W),
                       .MAX_BEATS(MAX_BEATS), .OUT_W(OUT_W)) dut (
    .clk(clk), .GlobalReset(GlobalReset), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .Pixels(Pixels), .Weights(Weights), .out_valid(out_valid),
    .out_ready(out_ready), .value(value), .overflow(overflow));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [LANES*PIX_W-1:0] pix_ramp();
    logic [LANES*PIX_W-1:0] p;
    for (int i = 0; i < LANES; i++) p[i*PIX_W +: PIX_W] = PIX_W'(i);
    return p;
  endfunction

  function automatic logic [LANES*PIX_W-1:0] pix_const(input logic [PIX_W-1:0] v);
    logic [LANES*PIX_W-1:0] p;
    for (int i = 0; i < LANES; i++) p[i*PIX_W +: PIX_W] = v;
    return p;
  endfunction

  function automatic logic [LANES*WGT_W-1:0] wgt_const(input logic [WGT_W-1:0] v);
    logic [LANES*WGT_W-1:0] w;
    for (int i = 0; i < LANES; i++) w[i*WGT_W +: WGT_W] = v;
    return w;
  endfunction

  // Reference: plain integer dot product in Q.16
  function automatic longint dot(input logic [LANES*PIX_W-1:0] p, input logic [LANES*WGT_W-1:0] w);
    longint s = 0;
    for (int i = 0; i < LANES; i++) begin
      longint pv = longint'(p[i*PIX_W +: PIX_W]);
      longint wv = longint'(w[i*WGT_W +: WGT_W]);
      if (wv >= (64'sd1 <<< (WGT_W - 1))) wv -= (64'sd1 <<< WGT_W);
      s += pv * wv;
    end
    return s;
  endfunction

  // Returns {overflow, value}
  function automatic logic [OUT_W:0] sat(input longint a);
    longint mx = (64'sd1 <<< (OUT_W - 1)) - 1;
    longint r;
    logic   o = 1'b0;
    if (a > mx) begin r = mx; o = 1'b1; end
    else if (a < -mx - 1) begin r = -mx - 1; o = 1'b1; end
    else r = a;
`ifdef DOTPROD_RELU_EN
    if (r < 0) begin r = 0; o = 1'b0; end
`endif
    return {o, r[OUT_W-1:0]};
  endfunction

  logic [OUT_W:0] exp_q[$];
  int             lat_q[$];
  longint         macc = 0;
  int             mbeats = 0;
  logic           prev_ov = 1'b0;

  always @(negedge clk) begin
    if (GlobalReset) begin
      exp_q.delete(); lat_q.delete();
      macc = 0; mbeats = 0; prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        macc += dot(Pixels, Weights);
        mbeats++;
        if (in_last || mbeats == MAX_BEATS) begin
          exp_q.push_back(sat(macc));
          lat_q.push_back(cyc + 1 + 3);
          macc = 0; mbeats = 0;
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
        else begin
          if (!prev_ov) check("latency_edge", cyc, lat_q[0]);
          check("model_value", value, exp_q[0][OUT_W-1:0]);
          check("model_overflow", overflow, exp_q[0][OUT_W]);
          check("in_ready_in_out", in_ready, 0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [LANES*PIX_W-1:0] p, input logic [LANES*WGT_W-1:0] w, input logic last);
    int n = 0;
    Pixels = p; Weights = w; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin n++; @(negedge clk); end
    if (!in_ready) check("beat_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output logic ok);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin n++; @(negedge clk); end
    ok = out_valid;
    if (!ok) check("out_valid_timeout", 0, 1);
  endtask

  task automatic expect_result(input string name, input logic [OUT_W-1:0] v, input logic o);
    logic ok;
    wait_out(ok);
    if (ok) begin
      check({name, "_value"}, value, v);
      check({name, "_overflow"}, overflow, o);
    end
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 GlobalReset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_value", value, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk); #1 GlobalReset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
  endtask

  localparam logic [WGT_W-1:0] W_P2 = 19'h20000, W_P1 = 19'h10000, W_N2 = 19'h60000,
                               W_MAX = 19'h3FFFF, W_MIN = 19'h40000;

  initial begin
    GlobalReset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    Pixels = '0; Weights = '0;
    repeat (2) @(posedge clk);
    pulse_reset();

    send(pix_ramp(), wgt_const(W_P2), 1'b1);
    expect_result("single_beat", 26'h05A0000, 1'b0);

    send(pix_ramp(), wgt_const(W_P2), 1'b0);
    send(pix_ramp(), wgt_const(W_P2), 1'b1);
    expect_result("two_beats", 26'h0B40000, 1'b0);

    send(pix_const(10'h3FF), wgt_const(W_MAX), 1'b1);
    expect_result("pos_sat", 26'h1FFFFFF, 1'b1);

`ifdef DOTPROD_RELU_EN
    send(pix_ramp(), wgt_const(W_N2), 1'b1);
    expect_result("neg_relu", 26'h0000000, 1'b0);
    send(pix_const(10'h3FF), wgt_const(W_MIN), 1'b1);
    expect_result("neg_sat_relu", 26'h0000000, 1'b0);
`else
    send(pix_ramp(), wgt_const(W_N2), 1'b1);
    expect_result("neg_value", 26'h3A60000, 1'b0);
    send(pix_const(10'h3FF), wgt_const(W_MIN), 1'b1);
    expect_result("neg_sat", 26'h2000000, 1'b1);
`endif

    // bubble carrying in_last must not end the vector
    send(pix_ramp(), wgt_const(W_P2), 1'b0);
    in_last = 1'b1; @(posedge clk); #1 in_last = 1'b0;
    send(pix_ramp(), wgt_const(W_P1), 1'b1);
    expect_result("bubble", 26'h0870000, 1'b0);

    // output backpressure while the next vector waits
    out_ready = 1'b0;
    send(pix_const(10'd1), wgt_const(W_P1), 1'b1);
    fork
      begin
        logic ok;
        wait_out(ok);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("hold_value", value, 26'h00A0000);
          check("hold_out_valid", out_valid, 1);
          check("hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
      send(pix_ramp(), wgt_const(W_P2), 1'b1);
    join
    expect_result("after_stall", 26'h05A0000, 1'b0);

    // reset in the middle of a vector discards the partial sum
    send(pix_ramp(), wgt_const(W_P2), 1'b0);
    send(pix_ramp(), wgt_const(W_P2), 1'b0);
    send(pix_ramp(), wgt_const(W_P2), 1'b0);
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("mid_rst_no_out", out_valid, 0);
    end
    @(posedge clk); #1;
    send(pix_ramp(), wgt_const(W_P2), 1'b1);
    expect_result("after_mid_rst", 26'h05A0000, 1'b0);

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
